// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencing control for the MIPS core.
// Latches the fetched instruction word, decodes it and steps FETCH -> DECODE -> EXEC -> MEM -> WB.
// It drives datapath and cache strobes one state at a time.
// It tracks the LL/SC link register against coherence snoops.
// A watchdog on the FETCH and MEM stalls can force the core into HALTED with err set.
//
// Ports
//   CLK, nRST            clock; synchronous active-low reset
//   iload, ihit          instruction word and icache hit
//   dhit                 dcache access completes this cycle
//   equal                ALU zero flag for branch compare
//   daddr                ALU result, used as the memory address in MEM
//   ccinv, ccsnoopaddr   coherence invalidate strobe and address
//   iREN, dREN, dWEN     instruction read, data read and data write requests
//   datomic              LL/SC access in progress
//   ALUop, ALU_Src       ALU operation and immediate-operand select
//   EXTop                immediate extend: 0 sign, 1 zero, 2 lui
//   PC_WEN, PC_Src       PC update strobe; 0 PC+4, 1 branch, 2 jump, 3 jr
//   RegWr, RegDst        register write strobe; destination 0 rt, 1 rd, 2 $31
//   Wsel, memtoReg       write-back select: 0 ALU/mem, 1 PC+4, 2 lui, 3 sc_ok; load data select
//   sc_ok                SC outcome, valid in WB
//   halt, err            sticky halt and sticky watchdog error
module multicycle_control_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINK_EN = 1,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TMO_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [31:0]       iload,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              equal,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              datomic,
    output logic [3:0]        ALUop,
    output logic              ALU_Src,
    output logic [1:0]        EXTop,
    output logic              PC_WEN,
    output logic [1:0]        PC_Src,
    output logic              RegWr,
    output logic [1:0]        RegDst,
    output logic [1:0]        Wsel,
    output logic              memtoReg,
    output logic              sc_ok,
    output logic              halt,
    output logic              err
);

    // Opcode encodings (opcode_t)
    localparam logic [5:0] OpRtype = 6'h00, OpJ    = 6'h02, OpJal  = 6'h03, OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05, OpAddi = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0a;
    localparam logic [5:0] OpSltiu = 6'h0b, OpAndi = 6'h0c, OpOri  = 6'h0d, OpXori  = 6'h0e;
    localparam logic [5:0] OpLui   = 6'h0f, OpLw   = 6'h23, OpSw   = 6'h2b, OpLl    = 6'h30;
    localparam logic [5:0] OpSc    = 6'h38, OpHalt = 6'h3f;
    // Function encodings (funct_t)
    localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnJr  = 6'h08, FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23, FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25, FnXor = 6'h26, FnNor = 6'h27, FnSlt  = 6'h2a;
    localparam logic [5:0] FnSltu = 6'h2b;
    // ALU operation encodings (aluop_t)
    localparam logic [3:0] AluSll = 4'd0, AluSrl = 4'd1, AluAdd = 4'd2, AluSub = 4'd3;
    localparam logic [3:0] AluAnd = 4'd4, AluOr  = 4'd5, AluXor = 4'd6, AluNor = 4'd7;
    localparam logic [3:0] AluSlt = 4'd8, AluSltu = 4'd9;

    localparam logic [TMO_W:0] TmoLimit = (TMO_W+1)'(TIMEOUT);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-3:0] link_addr_q, link_addr_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic              sc_ok_q, sc_ok_d;

    // Decoded fields
    logic [3:0] dec_aluop;
    logic       dec_alu_src, dec_memtoreg, dec_regwr;
    logic [1:0] dec_extop, dec_regdst, dec_wsel;
    logic       is_j, is_jal, is_jr, is_beq, is_bne, is_halt;
    logic       is_lw, is_sw, is_ll, is_sc;

    logic             sc_fail, stalled, tmo_hit, in_decoded;
    logic [TMO_W:0]   cnt_inc;
    logic             unused_bits;

    assign unused_bits = ^{ir_q[25:6], daddr[1:0], ccsnoopaddr[1:0]};

    always_comb begin
        dec_aluop    = AluSll;
        dec_alu_src  = 1'b0;
        dec_extop    = 2'd0;
        dec_regdst   = 2'd0;
        dec_wsel     = 2'd0;
        dec_memtoreg = 1'b0;
        dec_regwr    = 1'b0;
        is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        is_halt = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_ll = 1'b0; is_sc = 1'b0;
        unique case (ir_q[31:26])
            OpRtype: begin
                dec_regdst = 2'd1;
                dec_regwr  = 1'b1;
                unique case (ir_q[5:0])
                    FnSll:          dec_aluop = AluSll;
                    FnSrl:          dec_aluop = AluSrl;
                    FnAdd, FnAddu:  dec_aluop = AluAdd;
                    FnSub, FnSubu:  dec_aluop = AluSub;
                    FnAnd:          dec_aluop = AluAnd;
                    FnOr:           dec_aluop = AluOr;
                    FnXor:          dec_aluop = AluXor;
                    FnNor:          dec_aluop = AluNor;
                    FnSlt:          dec_aluop = AluSlt;
                    FnSltu:         dec_aluop = AluSltu;
                    FnJr: begin
                        is_jr      = 1'b1;
                        dec_regdst = 2'd0;
                        dec_regwr  = 1'b0;
                    end
                    default: begin // unknown funct behaves as a NOP
                        dec_regdst = 2'd0;
                        dec_regwr  = 1'b0;
                    end
                endcase
            end
            OpJ:  is_j = 1'b1;
            OpJal: begin
                is_jal     = 1'b1;
                dec_regdst = 2'd2;
                dec_wsel   = 2'd1;
            end
            OpBeq: begin is_beq = 1'b1; dec_aluop = AluSub; end
            OpBne: begin is_bne = 1'b1; dec_aluop = AluSub; end
            OpAddi, OpAddiu: begin dec_aluop = AluAdd;  dec_alu_src = 1'b1; dec_regwr = 1'b1; end
            OpSlti:          begin dec_aluop = AluSlt;  dec_alu_src = 1'b1; dec_regwr = 1'b1; end
            OpSltiu:         begin dec_aluop = AluSltu; dec_alu_src = 1'b1; dec_regwr = 1'b1; end
            OpAndi: begin
                dec_aluop = AluAnd; dec_alu_src = 1'b1; dec_extop = 2'd1; dec_regwr = 1'b1;
            end
            OpOri: begin
                dec_aluop = AluOr;  dec_alu_src = 1'b1; dec_extop = 2'd1; dec_regwr = 1'b1;
            end
            OpXori: begin
                dec_aluop = AluXor; dec_alu_src = 1'b1; dec_extop = 2'd1; dec_regwr = 1'b1;
            end
            OpLui: begin
                dec_alu_src = 1'b1; dec_extop = 2'd2; dec_wsel = 2'd2; dec_regwr = 1'b1;
            end
            OpLw: begin
                is_lw = 1'b1; dec_aluop = AluAdd; dec_alu_src = 1'b1;
                dec_memtoreg = 1'b1; dec_regwr = 1'b1;
            end
            OpLl: begin
                is_ll = 1'b1; dec_aluop = AluAdd; dec_alu_src = 1'b1;
                dec_memtoreg = 1'b1; dec_regwr = 1'b1;
            end
            OpSw: begin is_sw = 1'b1; dec_aluop = AluAdd; dec_alu_src = 1'b1; end
            OpSc: begin
                is_sc = 1'b1; dec_aluop = AluAdd; dec_alu_src = 1'b1;
                dec_wsel = 2'd3; dec_regwr = 1'b1;
            end
            OpHalt:  is_halt = 1'b1;
            default: ; // unknown opcode: NOP through WB
        endcase
    end

    // A tracked SC whose link is gone or points elsewhere never touches the cache.
    assign sc_fail = (LINK_EN != 0) && is_sc &&
                     (!link_valid_q || (link_addr_q != daddr[ADDR_W-1:2]));

    assign stalled = ((state_q == StFetch) && !ihit) ||
                     ((state_q == StMem) && !dhit && !sc_fail);
    assign cnt_inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
    // A hit clears `stalled`, so a hit on the limit cycle never raises err.
    assign tmo_hit = (TIMEOUT != 0) && stalled && (cnt_inc == TmoLimit);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        halt_d  = halt_q;
        err_d   = err_q;
        sc_ok_d = sc_ok_q;
        cnt_d   = (TIMEOUT != 0 && stalled && !tmo_hit) ? cnt_inc[TMO_W-1:0] : '0;
        case (state_q)
            StFetch: begin
                if (ihit) begin
                    ir_d    = iload;
                    state_d = StDecode;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    halt_d  = 1'b1;
                    state_d = StHalted;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (is_halt) begin
                    halt_d  = 1'b1;
                    state_d = StHalted;
                end else if (is_j || is_jal || is_jr || is_beq || is_bne) begin
                    state_d = StFetch;
                end else if (is_lw || is_sw || is_ll || is_sc) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (sc_fail) begin
                    sc_ok_d = 1'b0;
                    state_d = StWb;
                end else if (dhit) begin
                    sc_ok_d = is_sc;
                    state_d = StWb;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    halt_d  = 1'b1;
                    state_d = StHalted;
                end
            end
            StWb:     state_d = StFetch;
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if ((LINK_EN != 0) && (state_q == StMem)) begin
            if (is_ll && dhit) begin
                link_valid_d = 1'b1;
                link_addr_d  = daddr[ADDR_W-1:2];
            end
            if (is_sc && (dhit || sc_fail)) begin
                link_valid_d = 1'b0;
            end
        end
        // Compared against the next address so a snoop racing the LL hit still kills it.
        if (ccinv && (ccsnoopaddr[ADDR_W-1:2] == link_addr_d)) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= StFetch;
            ir_q         <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            cnt_q        <= '0;
            halt_q       <= 1'b0;
            err_q        <= 1'b0;
            sc_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            cnt_q        <= cnt_d;
            halt_q       <= halt_d;
            err_q        <= err_d;
            sc_ok_q      <= sc_ok_d;
        end
    end

    assign in_decoded = (state_q == StDecode) || (state_q == StExec) ||
                        (state_q == StMem) || (state_q == StWb);

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
        ALUop = 4'd0; ALU_Src = 1'b0; EXTop = 2'd0;
        PC_WEN = 1'b0; PC_Src = 2'd0; RegWr = 1'b0; RegDst = 2'd0; Wsel = 2'd0;
        memtoReg = 1'b0; sc_ok = 1'b0; halt = 1'b0; err = 1'b0;
        if (nRST) begin
            halt = halt_q;
            err  = err_q;
            if (in_decoded) begin
                ALUop    = dec_aluop;
                ALU_Src  = dec_alu_src;
                EXTop    = dec_extop;
                RegDst   = dec_regdst;
                Wsel     = dec_wsel;
                memtoReg = dec_memtoreg;
            end
            case (state_q)
                StFetch: iREN = 1'b1;
                StExec: begin
                    if (is_j || is_jal) begin
                        PC_WEN = 1'b1;
                        PC_Src = 2'd2;
                        RegWr  = is_jal;
                    end
                    if (is_jr) begin
                        PC_WEN = 1'b1;
                        PC_Src = 2'd3;
                    end
                    if (is_beq) begin
                        PC_WEN = 1'b1;
                        PC_Src = {1'b0, equal};
                    end
                    if (is_bne) begin
                        PC_WEN = 1'b1;
                        PC_Src = {1'b0, !equal};
                    end
                end
                StMem: begin
                    if (!sc_fail) begin
                        dREN    = is_lw || is_ll;
                        dWEN    = is_sw || is_sc;
                        datomic = is_ll || is_sc;
                    end
                end
                StWb: begin
                    PC_WEN = 1'b1;
                    RegWr  = dec_regwr;
                    sc_ok  = is_sc && sc_ok_q;
                end
                default: ;
            endcase
        end
    end

endmodule
